// File: rtl/mem_copy_engine_if.sv
// Control and memory-side signal bundle for mem_copy_engine.
// The checksum signal exists only when MEM_COPY_CHECKSUM_EN is defined.
interface mem_copy_engine_if;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;

  modport master (
    input  start, src_addr, dst_addr, word_count, mem_dout,
    output busy, done, error, mem_addr, mem_din, mem_read, mem_write, checksum
  );
  modport slave (
    output start, src_addr, dst_addr, word_count, mem_dout,
    input  busy, done, error, mem_addr, mem_din, mem_read, mem_write, checksum
  );
`else
  modport master (
    input  start, src_addr, dst_addr, word_count, mem_dout,
    output busy, done, error, mem_addr, mem_din, mem_read, mem_write
  );
  modport slave (
    output start, src_addr, dst_addr, word_count, mem_dout,
    input  busy, done, error, mem_addr, mem_din, mem_read, mem_write
  );
`endif
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word block copier driving a single-port memory: one read then one write per word.
// Optional running checksum of copied words when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
  parameter int unsigned MEM_DEPTH = 16384
) (
  input logic               clk,
  input logic               reset,
  mem_copy_engine_if.master bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [33:0] ByteLimit = 34'(MEM_DEPTH) << 2;

  logic [1:0]  state_q, state_d;
  logic [31:0] src_ptr_q, src_ptr_d;
  logic [31:0] dst_ptr_q, dst_ptr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;
`endif

  logic [33:0] src_end;
  logic [33:0] dst_end;
  logic        req_ok;

  // End addresses in 34 bits so a huge request can never wrap back into range.
  assign src_end = {2'b00, bus.src_addr} + {16'b0, bus.word_count, 2'b00};
  assign dst_end = {2'b00, bus.dst_addr} + {16'b0, bus.word_count, 2'b00};
  assign req_ok  = (bus.src_addr[1:0] == 2'b00) && (bus.dst_addr[1:0] == 2'b00) &&
                   (src_end <= ByteLimit) && (dst_end <= ByteLimit);

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    error_d     = 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (!req_ok) begin
            error_d = 1'b1;
          end else begin
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_d = '0;
`endif
            if (bus.word_count == 16'd0) begin
              state_d = StDone;
            end else begin
              src_ptr_d   = bus.src_addr;
              dst_ptr_d   = bus.dst_addr;
              remaining_d = bus.word_count;
              state_d     = StRead;
            end
          end
        end
      end
      StRead: begin
        data_d    = bus.mem_dout;
        src_ptr_d = src_ptr_q + 32'd4;
        state_d   = StWrite;
      end
      StWrite: begin
        dst_ptr_d   = dst_ptr_q + 32'd4;
        remaining_d = remaining_q - 16'd1;
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_d  = checksum_q + data_q;
`endif
        state_d     = (remaining_q == 16'd1) ? StDone : StRead;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    rd_d   = (state_d == StRead);
    wr_d   = (state_d == StWrite);
    case (state_d)
      StRead:  addr_d = src_ptr_d;
      StWrite: addr_d = dst_ptr_d;
      default: addr_d = '0;
    endcase
    din_d = (state_d == StWrite) ? data_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign bus.checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: expected memory writes are queued at stimulus time
// and popped as the engine strobes mem_write.
module tb_mem_copy_engine;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Aw    = $clog2(Depth);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_copy_engine_if bus ();

  mem_copy_engine #(.MEM_DEPTH(Depth)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [Depth];
  logic [31:0] ref_mem [Depth];
  logic          pl_en = 1'b0;
  logic [Aw-1:0] pl_idx = '0;
  logic [31:0]   pl_data = '0;

  assign bus.mem_dout = mem[bus.mem_addr[Aw+1:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.mem_write) mem[bus.mem_addr[Aw+1:2]] <= bus.mem_din;
  end

  int  n_vec = 0;
  int  n_err = 0;
  wr_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_read && bus.mem_write) check_val("strobe_excl", 32'd1, 32'd0);
    if (bus.mem_write) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_wr", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_addr", bus.mem_addr, e.addr);
        check_val("wr_data", bus.mem_din, e.data);
      end
    end
  end

  task automatic preload(input int unsigned idx, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_idx  = Aw'(idx);
    pl_data = d;
    ref_mem[idx] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Entered and left at a negedge with the engine idle, so calls run back to back.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] wc,
                          input int poke_cyc);
    logic [33:0] se, de;
    logic        valid;
    logic [31:0] d, cks;
    int          lim, done_cyc, err_cyc, busy1, busy_end, strobes;
    se    = {2'b00, src} + (34'(wc) << 2);
    de    = {2'b00, dst} + (34'(wc) << 2);
    valid = (src[1:0] == 2'b00) && (dst[1:0] == 2'b00) &&
            (se <= (34'(Depth) << 2)) && (de <= (34'(Depth) << 2));
    cks   = '0;
    if (valid) begin
      for (int i = 0; i < int'(wc); i++) begin
        d = ref_mem[int'(src >> 2) + i];
        ref_mem[int'(dst >> 2) + i] = d;
        exp_q.push_back('{addr: dst + 32'(4 * i), data: d});
        cks = cks + d;
      end
    end
    bus.start      = 1'b1;
    bus.src_addr   = src;
    bus.dst_addr   = dst;
    bus.word_count = wc;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lim      = valid ? 2 * int'(wc) + 2 : 2;
    done_cyc = 0;
    err_cyc  = 0;
    busy1    = 0;
    busy_end = 1;
    strobes  = 0;
    for (int cyc = 1; cyc <= lim; cyc++) begin
      @(negedge clk);
      if (cyc == poke_cyc) begin
        bus.start      = 1'b1;
        bus.src_addr   = 32'h3f0;
        bus.word_count = 16'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done && done_cyc == 0) done_cyc = cyc;
      if (bus.error && err_cyc == 0) err_cyc = cyc;
      if (bus.mem_read || bus.mem_write) strobes++;
      if (cyc == 1) busy1 = int'(bus.busy);
      if (cyc == lim) busy_end = int'(bus.busy);
    end
    bus.start = 1'b0;
    check_val("busy_c1", 32'(busy1), valid ? 32'd1 : 32'd0);
    check_val("busy_end", 32'(busy_end), 32'd0);
    check_val("done_cyc", 32'(done_cyc), valid ? 32'(2 * int'(wc) + 1) : 32'd0);
    check_val("err_cyc", 32'(err_cyc), valid ? 32'd0 : 32'd1);
    check_val("strobes", 32'(strobes), valid ? 32'(2 * int'(wc)) : 32'd0);
    check_val("wr_left", 32'(exp_q.size()), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    if (valid) check_val("checksum", bus.checksum, cks);
`endif
  endtask

  // 4-word copy aborted by reset sampled at the edge ending cycle 3: only word 0 lands.
  task automatic reset_abort(input logic [31:0] src, input logic [31:0] dst);
    int done_seen, late_wr;
    logic [31:0] d;
    d = ref_mem[int'(src >> 2)];
    ref_mem[int'(dst >> 2)] = d;
    exp_q.push_back('{addr: dst, data: d});
    bus.start      = 1'b1;
    bus.src_addr   = src;
    bus.dst_addr   = dst;
    bus.word_count = 16'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_seen = 0;
    late_wr   = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 3) reset = 1'b0;
      if (cyc == 4) reset = 1'b1;
      if (bus.done || bus.error) done_seen++;
      if (cyc >= 4 && (bus.mem_write || bus.mem_read)) late_wr++;
    end
    check_val("abort_done", 32'(done_seen), 32'd0);
    check_val("abort_strobe", 32'(late_wr), 32'd0);
    check_val("abort_wr_left", 32'(exp_q.size()), 32'd0);
    check_val("abort_w1", mem[int'(dst >> 2) + 1], ref_mem[int'(dst >> 2) + 1]);
`ifdef MEM_COPY_CHECKSUM_EN
    check_val("abort_cks", bus.checksum, 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start      = 1'b0;
    bus.src_addr   = '0;
    bus.dst_addr   = '0;
    bus.word_count = '0;
    reset          = 1'b0;
    @(negedge clk);
    for (int i = 0; i < int'(Depth); i++) preload(i, 32'h5a00_0000 + 32'(i));
    for (int i = 0; i < 4; i++) preload(32'h40 + i, 32'(i + 1));
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_error", 32'(bus.error), 32'd0);
    check_val("rst_rd", 32'(bus.mem_read), 32'd0);
    check_val("rst_wr", 32'(bus.mem_write), 32'd0);
    check_val("rst_addr", bus.mem_addr, 32'd0);
    check_val("rst_din", bus.mem_din, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    check_val("rst_cks", bus.checksum, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    run_copy(32'h100, 32'h200, 16'd4, 0);
    for (int i = 0; i < 4; i++) check_val("copy4_mem", mem[32'h80 + i], 32'(i + 1));
    run_copy(32'h100, 32'h240, 16'd0, 0);
    run_copy(32'h102, 32'h200, 16'd4, 0);
    run_copy(32'h100, 32'(4 * Depth - 4), 16'd2, 0);
    run_copy(32'h104, 32'h201, 16'd1, 0);
    run_copy(32'h10, 32'(4 * Depth - 8), 16'd2, 0);
    run_copy(32'h110, 32'h280, 16'd4, 3);
    reset_abort(32'h300, 32'h380);

    for (int i = 0; i < 4; i++) preload(i, 32'hA0 + 32'(i));
    run_copy(32'h0, 32'h4, 16'd3, 0);
    for (int i = 0; i < 4; i++) check_val("overlap_mem", mem[i], 32'hA0);

    preload(32'h50, 32'hffff_ffff);
    preload(32'h51, 32'h2);
    run_copy(32'h140, 32'h180, 16'd2, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    check_val("cks_wrap", bus.checksum, 32'h1);
    @(negedge clk);
    check_val("cks_hold", bus.checksum, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
